// File: rtl/fft_wb_unit.sv
// fft_wb_unit: write-back address unit for the in-place radix-2 FFT.
// Tracks issued butterflies in a FIFO, pairs them in order with BFU results,
// and writes the results to the opposite ping-pong bank.
// Optional feature macro: FFT_WB_BITREV_EN. When it is defined, writes of the
// final stage use bit-reversed addresses.
module fft_wb_unit #(
  parameter int unsigned N_LOG2     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               iss_valid,
  input  logic [N_LOG2-1:0]                  iss_addrA,
  input  logic [N_LOG2-1:0]                  iss_addrB,
  input  logic                               iss_bank,
  input  logic [N_LOG2-1:0]                  iss_stage,
  input  logic                               bfu_valid,
  input  logic [DATA_W-1:0]                  bfu_yA,
  input  logic [DATA_W-1:0]                  bfu_yB,
  output logic                               wr_en,
  output logic                               wr_bank,
  output logic [N_LOG2-1:0]                  wr_addrA,
  output logic [N_LOG2-1:0]                  wr_addrB,
  output logic [DATA_W-1:0]                  wr_dataA,
  output logic [DATA_W-1:0]                  wr_dataB,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    pending,
  output logic                               stage_done,
  output logic                               fft_done,
  output logic                               err_ovf,
  output logic                               err_unf
);

  localparam int unsigned PEND_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned WCNT_W = N_LOG2 - 1;

  typedef struct packed {
    logic [N_LOG2-1:0] addr_a;
    logic [N_LOG2-1:0] addr_b;
    logic              bank;
    logic [N_LOG2-1:0] stage;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  entry_t              fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PEND_W-1:0]   cnt_q, cnt_d;
  logic [WCNT_W-1:0]   wr_cnt_q, wr_cnt_d, eff_cnt;
  logic [N_LOG2-1:0]   cur_stage_q, cur_stage_d;
  logic [N_LOG2-1:0]   last_stage_q, last_stage_d;
  state_t              state_q, state_d;

  logic                wr_en_q, wr_en_d;
  logic                wr_bank_q, wr_bank_d;
  logic [N_LOG2-1:0]   wr_addr_a_q, wr_addr_a_d, wr_addr_b_q, wr_addr_b_d;
  logic [DATA_W-1:0]   wr_data_a_q, wr_data_a_d, wr_data_b_q, wr_data_b_d;
  logic                stage_done_q, stage_done_d;
  logic                fft_done_q, fft_done_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_unf_q, err_unf_d;

  logic                empty, full, pop_ok, push_ok, short_stage, last_wr;
  entry_t              head, new_entry;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef FFT_WB_BITREV_EN
  function automatic logic [N_LOG2-1:0] bit_rev(input logic [N_LOG2-1:0] x);
    for (int unsigned i = 0; i < N_LOG2; i++) bit_rev[i] = x[N_LOG2-1-i];
  endfunction
`endif

  // FIFO push/pop decisions and occupancy
  always_comb begin
    empty            = (cnt_q == '0);
    full             = (cnt_q == PEND_W'(FIFO_DEPTH));
    pop_ok           = bfu_valid && !empty;
    push_ok          = iss_valid && (!full || pop_ok);
    head             = fifo_q[rd_ptr_q];
    new_entry.addr_a = iss_addrA;
    new_entry.addr_b = iss_addrB;
    new_entry.bank   = iss_bank;
    new_entry.stage  = iss_stage;
    rd_ptr_d         = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d         = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    last_stage_d     = push_ok ? iss_stage : last_stage_q;
    cnt_d            = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + PEND_W'(1);
    if (pop_ok && !push_ok) cnt_d = cnt_q - PEND_W'(1);
  end

  // Write outputs, per-stage write counting and stage/transform completion
  always_comb begin
    wr_en_d      = pop_ok;
    wr_bank_d    = wr_bank_q;
    wr_addr_a_d  = wr_addr_a_q;
    wr_addr_b_d  = wr_addr_b_q;
    wr_data_a_d  = wr_data_a_q;
    wr_data_b_d  = wr_data_b_q;
    wr_cnt_d     = wr_cnt_q;
    cur_stage_d  = cur_stage_q;
    short_stage  = pop_ok && (head.stage != cur_stage_q) && (wr_cnt_q != '0);
    eff_cnt      = short_stage ? '0 : wr_cnt_q;
    last_wr      = (eff_cnt == '1);
    stage_done_d = pop_ok && last_wr;
    fft_done_d   = stage_done_d && (head.stage == N_LOG2'(N_LOG2 - 1));
    if (pop_ok) begin
      wr_bank_d   = ~head.bank;
      wr_addr_a_d = head.addr_a;
      wr_addr_b_d = head.addr_b;
`ifdef FFT_WB_BITREV_EN
      if (head.stage == N_LOG2'(N_LOG2 - 1)) begin
        wr_addr_a_d = bit_rev(head.addr_a);
        wr_addr_b_d = bit_rev(head.addr_b);
      end
`endif
      wr_data_a_d = bfu_yA;
      wr_data_b_d = bfu_yB;
      wr_cnt_d    = last_wr ? '0 : eff_cnt + WCNT_W'(1);
      cur_stage_d = head.stage;
    end
  end

  // Phase tracking and sticky error flags
  always_comb begin
    state_d   = state_q;
    err_unf_d = err_unf_q || (bfu_valid && empty) || short_stage;
    err_ovf_d = err_ovf_q || (iss_valid && full && !pop_ok) ||
                ((state_q == DRAIN) && iss_valid && (iss_stage < last_stage_q));
    unique case (state_q)
      IDLE:   if (push_ok) state_d = ACTIVE;
      ACTIVE: begin
        if (stage_done_d && (cnt_d != '0))           state_d = DRAIN;
        else if ((cnt_d == '0) && (wr_cnt_d == '0))  state_d = IDLE;
      end
      DRAIN: begin
        if (push_ok)                                 state_d = ACTIVE;
        else if ((cnt_d == '0) && (wr_cnt_d == '0))  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tracking FIFO storage; stale contents are harmless once pointers reset
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= new_entry;
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      wr_cnt_q     <= '0;
      cur_stage_q  <= '0;
      last_stage_q <= '0;
      state_q      <= IDLE;
      wr_en_q      <= 1'b0;
      wr_bank_q    <= 1'b0;
      wr_addr_a_q  <= '0;
      wr_addr_b_q  <= '0;
      wr_data_a_q  <= '0;
      wr_data_b_q  <= '0;
      stage_done_q <= 1'b0;
      fft_done_q   <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_unf_q    <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      cur_stage_q  <= cur_stage_d;
      last_stage_q <= last_stage_d;
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_bank_q    <= wr_bank_d;
      wr_addr_a_q  <= wr_addr_a_d;
      wr_addr_b_q  <= wr_addr_b_d;
      wr_data_a_q  <= wr_data_a_d;
      wr_data_b_q  <= wr_data_b_d;
      stage_done_q <= stage_done_d;
      fft_done_q   <= fft_done_d;
      err_ovf_q    <= err_ovf_d;
      err_unf_q    <= err_unf_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_bank    = wr_bank_q;
  assign wr_addrA   = wr_addr_a_q;
  assign wr_addrB   = wr_addr_b_q;
  assign wr_dataA   = wr_data_a_q;
  assign wr_dataB   = wr_data_b_q;
  assign pending    = cnt_q;
  assign stage_done = stage_done_q;
  assign fft_done   = fft_done_q;
  assign err_ovf    = err_ovf_q;
  assign err_unf    = err_unf_q;

endmodule

// File: tb/tb_fft_wb_unit.sv
// Bench for fft_wb_unit with N_LOG2=3, FIFO_DEPTH=4, BFU latency 2.
// Honours FFT_WB_BITREV_EN when the build defines it.
module tb_fft_wb_unit;

  localparam int HALF_N     = 4;
  localparam int LAST_STAGE = 2;
  localparam int DEPTH      = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_bank, bfu_valid;
  logic [2:0]  iss_addrA, iss_addrB, iss_stage;
  logic [31:0] bfu_yA, bfu_yB;
  logic        wr_en, wr_bank, stage_done, fft_done, err_ovf, err_unf;
  logic [2:0]  wr_addrA, wr_addrB, pending;
  logic [31:0] wr_dataA, wr_dataB;

  fft_wb_unit #(.N_LOG2(3), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_addrA(iss_addrA), .iss_addrB(iss_addrB),
    .iss_bank(iss_bank), .iss_stage(iss_stage),
    .bfu_valid(bfu_valid), .bfu_yA(bfu_yA), .bfu_yB(bfu_yB),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addrA(wr_addrA), .wr_addrB(wr_addrB),
    .wr_dataA(wr_dataA), .wr_dataB(wr_dataB), .pending(pending),
    .stage_done(stage_done), .fft_done(fft_done),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  typedef struct {int a; int b; int bank; int stage;} ent_t;

  int checks = 0;
  int errors = 0;
  int dctr = 0;

  // reference model state
  ent_t        mq[$];
  int          m_nwr, m_cur, m_last;
  bit          m_dr;
  logic        e_wr_en, e_bank, e_sd, e_fd, e_ovf, e_unf;
  int          e_a, e_b;
  logic [31:0] e_da, e_db;

  // stimulus list and write log
  ent_t iq[$];
  int   la[$], lb[$], lbank[$];
  int   n_sd = 0, n_fd = 0, sd_at = 0, fd_at = 0;

  function automatic int brev3(input int x);
    logic [2:0] v;
    v = 3'(x);
    return int'({v[0], v[1], v[2]});
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One cycle of the reference model, applied with the inputs seen at the edge
  task automatic model_step();
    ent_t e;
    bit   acc, old_dr;
    if (rst) begin
      mq.delete(); m_nwr = 0; m_cur = 0; m_last = 0; m_dr = 0;
      e_wr_en = 0; e_bank = 0; e_a = 0; e_b = 0; e_da = 0; e_db = 0;
      e_sd = 0; e_fd = 0; e_ovf = 0; e_unf = 0;
      return;
    end
    old_dr = m_dr; acc = 0;
    e_wr_en = 0; e_sd = 0; e_fd = 0;
    if (bfu_valid) begin
      if (mq.size() == 0) e_unf = 1;
      else begin
        e = mq.pop_front();
        e_wr_en = 1; e_bank = (e.bank == 0); e_a = e.a; e_b = e.b;
`ifdef FFT_WB_BITREV_EN
        if (e.stage == LAST_STAGE) begin e_a = brev3(e.a); e_b = brev3(e.b); end
`endif
        e_da = bfu_yA; e_db = bfu_yB;
        if (e.stage != m_cur && m_nwr != 0) begin e_unf = 1; m_nwr = 0; end
        m_cur = e.stage;
        m_nwr++;
        if (m_nwr == HALF_N) begin
          e_sd = 1; m_nwr = 0;
          if (e.stage == LAST_STAGE) e_fd = 1;
        end
      end
    end
    if (iss_valid) begin
      if (old_dr && int'(iss_stage) < m_last) e_ovf = 1;
      if (mq.size() < DEPTH) begin
        mq.push_back('{int'(iss_addrA), int'(iss_addrB), int'(iss_bank), int'(iss_stage)});
        acc = 1; m_last = int'(iss_stage);
      end else e_ovf = 1;
    end
    if (old_dr) begin
      if (acc || (mq.size() == 0 && m_nwr == 0)) m_dr = 0;
    end else if (e_sd && mq.size() != 0) m_dr = 1;
  endtask

  // Advance one clock: model at the edge, compare and log on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("pending", int'(pending), mq.size());
    chk("wr_en", int'(wr_en), int'(e_wr_en));
    chk("stage_done", int'(stage_done), int'(e_sd));
    chk("fft_done", int'(fft_done), int'(e_fd));
    chk("err_ovf", int'(err_ovf), int'(e_ovf));
    chk("err_unf", int'(err_unf), int'(e_unf));
    if (e_wr_en) begin
      chk("wr_bank", int'(wr_bank), int'(e_bank));
      chk("wr_addrA", int'(wr_addrA), e_a);
      chk("wr_addrB", int'(wr_addrB), e_b);
      chk("wr_dataA", int'(wr_dataA), int'(e_da));
      chk("wr_dataB", int'(wr_dataB), int'(e_db));
    end
    if (wr_en) begin
      la.push_back(int'(wr_addrA)); lb.push_back(int'(wr_addrB));
      lbank.push_back(int'(wr_bank));
    end
    if (stage_done) begin n_sd++; sd_at = la.size(); end
    if (fft_done) begin n_fd++; fd_at = la.size(); end
  endtask

  task automatic set_idle();
    iss_valid = 0; iss_addrA = 0; iss_addrB = 0; iss_bank = 0; iss_stage = 0;
    bfu_valid = 0; bfu_yA = 0; bfu_yB = 0;
  endtask

  task automatic do_reset();
    set_idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic add_iss(input int a, input int b, input int bank, input int stage);
    iq.push_back('{a, b, bank, stage});
  endtask

  task automatic set_bfu();
    dctr++;
    bfu_valid = 1;
    bfu_yA = 32'hA000_0000 | 32'(dctr);
    bfu_yB = 32'hB000_0000 | 32'(dctr);
  endtask

  // Issue the queued butterflies back to back; results follow two cycles later
  task automatic run_pipe();
    int n;
    n = iq.size();
    for (int c = 0; c < n + 2; c++) begin
      set_idle();
      if (c < n) begin
        iss_valid = 1;
        iss_addrA = 3'(iq[c].a); iss_addrB = 3'(iq[c].b);
        iss_bank = 1'(iq[c].bank); iss_stage = 3'(iq[c].stage);
      end
      if (c >= 2) set_bfu();
      tick();
    end
    set_idle(); tick();
    iq.delete();
  endtask

  initial begin
    int base, sd0, fd0, seen;
    set_idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_errs", int'({err_ovf, err_unf}), 0);

    // single stage
    base = la.size(); sd0 = n_sd; fd0 = n_fd;
    for (int k = 0; k < 4; k++) add_iss(2 * k, 2 * k + 1, 0, 0);
    run_pipe();
    chk("t1_writes", la.size() - base, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_addrA", la[base + k], 2 * k);
      chk("t1_addrB", lb[base + k], 2 * k + 1);
      chk("t1_bank", lbank[base + k], 1);
    end
    chk("t1_sd_count", n_sd - sd0, 1);
    chk("t1_sd_on_4th", sd_at, base + 4);
    chk("t1_fd_count", n_fd - fd0, 0);

    // three stages back to back, alternating banks
    do_reset();
    base = la.size(); sd0 = n_sd; fd0 = n_fd;
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 4; k++) add_iss(2 * k, 2 * k + 1, s % 2, s);
    run_pipe();
    chk("t2_writes", la.size() - base, 12);
    chk("t2_sd_count", n_sd - sd0, 3);
    chk("t2_fd_count", n_fd - fd0, 1);
    chk("t2_fd_on_12th", fd_at, base + 12);
    chk("t2_bank_s0", lbank[base], 1);
    chk("t2_bank_s1", lbank[base + 4], 0);
    chk("t2_bank_s2", lbank[base + 8], 1);
    chk("t2_pending", int'(pending), 0);
    chk("t2_errs", int'({err_ovf, err_unf}), 0);

    // overflow: five pushes, no results
    do_reset();
    base = la.size();
    for (int k = 0; k < 5; k++) begin
      set_idle();
      iss_valid = 1; iss_addrA = 3'(k); iss_addrB = 3'(7 - k);
      tick();
    end
    set_idle(); tick();
    chk("t3_pending_full", int'(pending), 4);
    chk("t3_err_ovf", int'(err_ovf), 1);
    for (int k = 0; k < 5; k++) begin set_idle(); set_bfu(); tick(); end
    set_idle(); tick();
    chk("t3_writes", la.size() - base, 4);
    seen = 0;
    for (int k = base; k < la.size(); k++) if (la[k] == 4) seen = 1;
    chk("t3_no_5th", seen, 0);

    // underflow
    do_reset();
    base = la.size();
    set_idle(); set_bfu(); tick();
    set_idle();
    chk("t4_wr_en", int'(wr_en), 0);
    chk("t4_err_unf", int'(err_unf), 1);
    tick(); tick(); tick();
    chk("t4_unf_sticky", int'(err_unf), 1);
    chk("t4_no_write", la.size() - base, 0);
    do_reset();
    chk("t4_unf_cleared", int'(err_unf), 0);

    // reset mid-stage
    base = la.size();
    for (int k = 0; k < 2; k++) begin
      set_idle(); iss_valid = 1; iss_addrA = 3'(2 * k); iss_addrB = 3'(2 * k + 1);
      tick();
    end
    do_reset();
    chk("t5_pending", int'(pending), 0);
    for (int k = 0; k < 2; k++) begin set_idle(); set_bfu(); tick(); end
    set_idle(); tick();
    chk("t5_no_write", la.size() - base, 0);

    // final-stage addressing
    do_reset();
    base = la.size();
    add_iss(1, 5, 0, 2); run_pipe();
    add_iss(1, 5, 1, 0); run_pipe();
`ifdef FFT_WB_BITREV_EN
    chk("t6_s2_addrA", la[base], 4);
`else
    chk("t6_s2_addrA", la[base], 1);
`endif
    chk("t6_s2_addrB", lb[base], 5);
    chk("t6_s0_addrA", la[base + 1], 1);
    chk("t6_s0_addrB", lb[base + 1], 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
